// File: rtl/grid_arb_pkg.sv
// Shared types and constants for the placement-grid port arbiter.
package grid_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int GRID_ADDR_W = 12;
  localparam int GRID_DATA_W = 32;
  localparam logic [GRID_DATA_W-1:0] GRID_EMPTY = 32'hFFFFFFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot round-robin picker; ptr names the highest-priority requester.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  function automatic logic [PW-1:0] idx_of(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[PW-1:0];
  endfunction

  // Walk from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[idx_of(ptr, k)]) begin
        gnt = '0;
        gnt[idx_of(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing one grid RAM port; GRID_ARB_LOCK_EN adds owner lock with timeout.
// Grant is combinational (0 cycles), read data returns 1 cycle later; losers simply hold req.
module grid_port_arbiter
  import grid_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = GRID_ADDR_W,
  parameter int DATA_W   = GRID_DATA_W,
  parameter int LOCK_TMO = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     lock_err
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] rvalid_q;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any, gnt_we, gnt_lock;

  function automatic logic [PW-1:0] next_of(input logic [PW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_any   = |gnt;
    gnt_idx   = '0;
    gnt_we    = 1'b0;
    gnt_lock  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = PW'(i);
        gnt_we    = req_we[i];
        gnt_lock  = req_lock[i];
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign mem_re = gnt_any & ~gnt_we;
  assign mem_we = gnt_any & gnt_we;
  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= gnt & ~req_we;
    end
  end

`ifdef GRID_ARB_LOCK_EN
  localparam int IW = $clog2(LOCK_TMO + 1);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          tmo;

  // While locked only the owner is eligible; everyone else just waits.
  always_comb begin
    elig = req;
    if (state_q == LOCKED) elig = req & (NREQ'(1) << owner_q);
    if (reset) elig = '0;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idle_d  = idle_q;
    ptr_d   = gnt_any ? next_of(gnt_idx) : ptr_q;
    tmo     = 1'b0;
    case (state_q)
      ARB: begin
        if (gnt_any && gnt_lock) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
          idle_d  = '0;
        end
      end
      LOCKED: begin
        if (gnt_any) begin
          idle_d = '0;
          if (!gnt_lock) state_d = ARB;
        end else if (idle_q >= IW'(LOCK_TMO - 1)) begin
          tmo     = 1'b1;
          state_d = ARB;
          ptr_d   = next_of(owner_q);
          idle_d  = '0;
        end else if (idle_q != IW'(LOCK_TMO)) begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      idle_q  <= idle_d;
    end
  end

  assign lock_err = tmo & ~reset;
`else
  logic unused_lock;

  assign elig        = reset ? '0 : req;
  assign ptr_d       = gnt_any ? next_of(gnt_idx) : ptr_q;
  assign lock_err    = 1'b0;
  assign unused_lock = gnt_lock;
`endif

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Self-checking bench for grid_port_arbiter: vector table, corner sequences, random vs reference model.
module tb_grid_port_arbiter;
  import grid_arb_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int TMO = 16;
`ifdef GRID_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_we, req_lock, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            mem_re, mem_we, lock_err;
  logic [AW-1:0]   mem_addr;

  logic [DW-1:0]   grid [4096];
  logic            init_grid;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int           m_p, m_owner, m_idle;
  bit           m_locked;
  logic [N-1:0] m_rv;
  logic [DW-1:0] m_rdata;

  // DUT outputs sampled at the last step
  logic [N-1:0]  smp_gnt, smp_rv;
  logic [DW-1:0] smp_rdata;
  logic          smp_le;

  always #5 clk = ~clk;

  grid_port_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  always @(posedge clk) begin
    if (init_grid) begin
      for (int k = 0; k < 4096; k++) grid[k] = GRID_EMPTY;
      grid[10] = 32'h5;
    end else begin
      if (mem_we) grid[mem_addr] = mem_wdata;
      if (mem_re) mem_rdata <= grid[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    req_we[i] = we;
    req_lock[i] = lk;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic step();
    int g, c;
    logic [N-1:0] eg;
    logic le;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        c = (m_p + k) % N;
        if (g < 0 && req[c] && (!m_locked || c == m_owner)) g = c;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    le = !reset && m_locked && g < 0 && m_idle == TMO - 1;
    smp_gnt = gnt; smp_rv = rvalid; smp_rdata = rdata; smp_le = lock_err;
    chk("gnt", gnt, eg);
    chk("mem_re", mem_re, (g >= 0) ? !req_we[g] : 1'b0);
    chk("mem_we", mem_we, (g >= 0) ? req_we[g] : 1'b0);
    chk("mem_addr", mem_addr, (g >= 0) ? req_addr[g*AW +: AW] : '0);
    chk("mem_wdata", mem_wdata, (g >= 0) ? req_wdata[g*DW +: DW] : '0);
    chk("rvalid", rvalid, m_rv);
    if (m_rv != 0) chk("rdata", rdata, m_rdata);
    chk("lock_err", lock_err, le);
    if (reset) begin
      m_p = 0; m_locked = 0; m_idle = 0; m_rv = '0;
    end else begin
      m_rv = '0;
      if (g >= 0 && !req_we[g]) begin
        m_rv[g] = 1'b1;
        m_rdata = grid[req_addr[g*AW +: AW]];
      end
      if (g >= 0) m_p = (g + 1) % N;
      if (LOCK_EN) begin
        if (g >= 0) begin
          if (m_locked) m_locked = req_lock[g];
          else if (req_lock[g]) begin m_locked = 1; m_owner = g; end
          m_idle = 0;
        end else if (m_locked) begin
          if (le) begin m_locked = 0; m_p = (m_owner + 1) % N; m_idle = 0; end
          else m_idle++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  rq;
    logic [AW-1:0] a0, a1;
    logic [N-1:0]  egnt, erv;
    logic [DW-1:0] erdata;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int tr, tw, t0, t_err, n_err, t_g1, ph1, n_le;
    bit g0_between;

    reset = 1'b1; init_grid = 1'b1;
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    m_p = 0; m_owner = 0; m_idle = 0; m_locked = 0; m_rv = '0; m_rdata = '0;
    repeat (3) @(posedge clk);
    #1 init_grid = 1'b0;

    //              rst  req    a0  a1  egnt   erv    erdata
    tbl[0]  = '{1'b1, 2'b00, 10, 0,  2'b00, 2'b00, '0};
    tbl[1]  = '{1'b0, 2'b01, 10, 0,  2'b01, 2'b00, '0};
    tbl[2]  = '{1'b0, 2'b00, 10, 0,  2'b00, 2'b01, 32'h5};
    tbl[3]  = '{1'b1, 2'b11, 20, 21, 2'b00, 2'b00, '0};
    tbl[4]  = '{1'b0, 2'b11, 20, 21, 2'b01, 2'b00, '0};
    tbl[5]  = '{1'b0, 2'b11, 20, 21, 2'b10, 2'b01, GRID_EMPTY};
    tbl[6]  = '{1'b0, 2'b11, 20, 21, 2'b01, 2'b10, GRID_EMPTY};
    tbl[7]  = '{1'b0, 2'b11, 20, 21, 2'b10, 2'b01, GRID_EMPTY};
    tbl[8]  = '{1'b0, 2'b11, 20, 21, 2'b01, 2'b10, GRID_EMPTY};
    tbl[9]  = '{1'b0, 2'b11, 20, 21, 2'b10, 2'b01, GRID_EMPTY};
    tbl[10] = '{1'b0, 2'b00, 20, 21, 2'b00, 2'b10, GRID_EMPTY};

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst;
      set_req(0, tbl[i].rq[0], 1'b0, 1'b0, tbl[i].a0, '0);
      set_req(1, tbl[i].rq[1], 1'b0, 1'b0, tbl[i].a1, '0);
      step();
      chk($sformatf("tbl%0d_gnt", i), smp_gnt, tbl[i].egnt);
      chk($sformatf("tbl%0d_rvalid", i), smp_rv, tbl[i].erv);
      if (tbl[i].erv != 0) chk($sformatf("tbl%0d_rdata", i), smp_rdata, tbl[i].erdata);
    end
    reset = 1'b0;

    // check-and-write of cell 48 by requester 1 while requester 0 keeps asking
    do_reset();
    tr = -1; tw = -1; ph1 = 0; g0_between = 0; t0 = -1; n_le = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 1'b0, 1'b0, 12'd5, '0);
      set_req(1, ph1 < 2, ph1 == 1, ph1 == 0, 12'd48, 32'd7);
      step();
      if (smp_le) n_le++;
      if (smp_gnt[0] && tr >= 0 && tw < 0) g0_between = 1;
      if (smp_gnt[0] && tw >= 0 && t0 < 0) t0 = c;
      if (tr >= 0 && c == tr + 1) begin
        chk("atomic_rvalid", smp_rv, 2'b10);
        chk("atomic_rdata_empty", smp_rdata, GRID_EMPTY);
      end
      if (smp_gnt[1]) begin
        if (ph1 == 0) tr = c; else if (ph1 == 1) tw = c;
        ph1++;
      end
    end
    chk("atomic_read_cycle", tr, 1);
    chk("atomic_write_cycle", tw, LOCK_EN ? 2 : 3);
    chk("atomic_req0_between", g0_between, !LOCK_EN);
    chk("atomic_req0_after_write", t0, tw + 1);
    chk("atomic_cell48", grid[48], 32'd7);
    chk("atomic_no_lock_err", n_le, 0);
    req = '0;

    // lock timeout: requester 0 locks then goes idle while requester 1 waits
    do_reset();
    set_req(0, 1'b1, 1'b0, 1'b1, 12'd7, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, 12'd8, '0);
    step();
    chk("tmo_lock_gnt", smp_gnt, 2'b01);
    set_req(0, 1'b0, 1'b0, 1'b0, 12'd7, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'd8, '0);
    t_err = -1; n_err = 0; t_g1 = -1;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (smp_le) begin n_err++; if (t_err < 0) t_err = c; end
      if (smp_gnt[1] && t_g1 < 0) begin t_g1 = c; req[1] = 1'b0; end
    end
    chk("tmo_err_cycle", t_err, LOCK_EN ? TMO : -1);
    chk("tmo_err_count", n_err, LOCK_EN ? 1 : 0);
    chk("tmo_req1_gnt_cycle", t_g1, LOCK_EN ? TMO + 1 : 1);

    // reset while locked with a read outstanding
    do_reset();
    set_req(0, 1'b0, 1'b0, 1'b0, 12'd3, '0);
    set_req(1, 1'b1, 1'b0, 1'b1, 12'd48, '0);
    step();
    chk("rst_lock_gnt", smp_gnt, 2'b10);
    reset = 1'b1; req = '0;
    step();
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 12'd3, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'd4, '0);
    step();
    chk("rst_after_gnt", smp_gnt, 2'b01);
    chk("rst_after_rvalid", smp_rv, 2'b00);
    req = '0;
    step();

    // random traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req[i] && !smp_gnt[i])) begin
          set_req(i, $urandom_range(0, 9) < (((cyc / 400) % 2) ? 1 : 6),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 2,
                  12'($urandom_range(0, 63)), $urandom);
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
